// File: rtl/contadores_resp.sv
// contadores_resp: word-counter responder for the PCIe layer.
// Counts successful pops on output FIFOs 5..8 and answers req/idx reads
// with the selected count one cycle later while the layer FSM is idle.
// Optional build macro: CONTADORES_CLR_ON_READ_EN (clear-on-read counters).
module contadores_resp #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned FIFO_UNITS = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             idle,
    input  logic             fifo5_rd,
    input  logic             fifo5_empty,
    input  logic             fifo6_rd,
    input  logic             fifo6_empty,
    input  logic             fifo7_rd,
    input  logic             fifo7_empty,
    input  logic             fifo8_rd,
    input  logic             fifo8_empty,
    input  logic             req,
    input  logic [1:0]       idx,
    output logic [CNT_W-1:0] data_out_contador,
    output logic             valids
);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q [FIFO_UNITS];
    logic [CNT_W-1:0]      cnt_d [FIFO_UNITS];
    logic [CNT_W-1:0]      data_q, data_d;
    logic [FIFO_UNITS-1:0] rd_v, empty_v, pop;
    logic                  accept;

    assign rd_v    = {fifo8_rd, fifo7_rd, fifo6_rd, fifo5_rd};
    assign empty_v = {fifo8_empty, fifo7_empty, fifo6_empty, fifo5_empty};

    // Pop qualification and read acceptance
    always_comb begin
        pop    = rd_v & ~empty_v;
        accept = req & idle;
    end

    // Next-state and response sample; data is the pre-update count
    always_comb begin
        state_d = state_q;
        data_d  = '0;
        case (state_q)
            ST_WAIT: begin
                if (accept) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (!accept) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
        if (accept) data_d = cnt_q[idx];
    end

    // Per-FIFO counter update, wrapping modulo 2^CNT_W
    always_comb begin
        for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pop[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
`ifdef CONTADORES_CLR_ON_READ_EN
            // a same-cycle pop survives the clear, leaving the counter at 1
            if (accept && (32'(idx) == i)) cnt_d[i] = pop[i] ? CNT_W'(1) : '0;
`endif
        end
    end

    // State, response and counter registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_WAIT;
            data_q  <= '0;
            for (int unsigned i = 0; i < FIFO_UNITS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            for (int unsigned i = 0; i < FIFO_UNITS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign valids            = (state_q == ST_SERVE);
    assign data_out_contador = data_q;

endmodule

// File: tb/tb_contadores_resp.sv
// Directed testbench for contadores_resp.
module tb_contadores_resp;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       idle = 1'b1;
    logic       fifo5_rd = 1'b0, fifo5_empty = 1'b0;
    logic       fifo6_rd = 1'b0, fifo6_empty = 1'b0;
    logic       fifo7_rd = 1'b0, fifo7_empty = 1'b0;
    logic       fifo8_rd = 1'b0, fifo8_empty = 1'b0;
    logic       req = 1'b0;
    logic [1:0] idx = 2'd0;
    logic [4:0] data_out_contador;
    logic       valids;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    contadores_resp #(.CNT_W(5), .FIFO_UNITS(4)) dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .idle              (idle),
        .fifo5_rd          (fifo5_rd),
        .fifo5_empty       (fifo5_empty),
        .fifo6_rd          (fifo6_rd),
        .fifo6_empty       (fifo6_empty),
        .fifo7_rd          (fifo7_rd),
        .fifo7_empty       (fifo7_empty),
        .fifo8_rd          (fifo8_rd),
        .fifo8_empty       (fifo8_empty),
        .req               (req),
        .idx               (idx),
        .data_out_contador (data_out_contador),
        .valids            (valids)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic read_one(input logic [1:0] sel, input int unsigned exp, input string tag);
        req = 1'b1;
        idx = sel;
        tick();
        check({tag, "_valid"}, 32'(valids), 32'd1);
        check({tag, "_data"}, 32'(data_out_contador), 32'(exp));
        req = 1'b0;
        tick();
    endtask

    initial begin
        // reset state
        #1;
        check("rst_valids", 32'(valids), 32'd0);
        check("rst_data", 32'(data_out_contador), 32'd0);
        tick();
        reset_L = 1'b1;
        tick();

        // back-to-back reads, no pops
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            tick();
            check($sformatf("b2b_valid%0d", i), 32'(valids), 32'd1);
            check($sformatf("b2b_data%0d", i), 32'(data_out_contador), 32'd0);
        end
        req = 1'b0;
        tick();
        check("b2b_drop_valid", 32'(valids), 32'd0);
        check("b2b_drop_data", 32'(data_out_contador), 32'd0);

        // 6 pops on 5/6/7, fifo8 strobed while empty
        for (int i = 0; i < 6; i++) begin
            fifo5_rd = 1'b1; fifo6_rd = 1'b1; fifo7_rd = 1'b1;
            fifo8_rd = (i < 3); fifo8_empty = 1'b1;
            tick();
        end
        fifo5_rd = 1'b0; fifo6_rd = 1'b0; fifo7_rd = 1'b0; fifo8_rd = 1'b0;
        fifo8_empty = 1'b0;
        read_one(2'd0, 6, "cnt5");
        read_one(2'd1, 6, "cnt6");
        read_one(2'd2, 6, "cnt7");
        read_one(2'd3, 0, "cnt8_empty");

        // wrap: 33 pops -> 1
        do_reset();
        fifo5_rd = 1'b1;
        repeat (33) tick();
        fifo5_rd = 1'b0;
        read_one(2'd0, 1, "wrap");

        // req ignored while not idle
        fifo6_rd = 1'b1;
        repeat (3) tick();
        fifo6_rd = 1'b0;
        idle = 1'b0;
        req = 1'b1;
        idx = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("notidle_valid%0d", i), 32'(valids), 32'd0);
            check($sformatf("notidle_data%0d", i), 32'(data_out_contador), 32'd0);
        end
        idle = 1'b1;
        tick();
        check("idle_resume_valid", 32'(valids), 32'd1);
        check("idle_resume_data", 32'(data_out_contador), 32'd3);
        req = 1'b0;
        tick();

        // pop and read of the same counter in one cycle
        fifo7_rd = 1'b1;
        repeat (4) tick();
        req = 1'b1;
        idx = 2'd2;
        tick();
        check("samecyc_data", 32'(data_out_contador), 32'd4);
        fifo7_rd = 1'b0;
        tick();
`ifdef CONTADORES_CLR_ON_READ_EN
        check("reread_data", 32'(data_out_contador), 32'd1);
`else
        check("reread_data", 32'(data_out_contador), 32'd5);
`endif
        req = 1'b0;
        tick();

        // async reset during SERVE
        do_reset();
        fifo5_rd = 1'b1;
        repeat (10) tick();
        fifo5_rd = 1'b0;
        req = 1'b1;
        idx = 2'd0;
        tick();
        check("pre_rst_data", 32'(data_out_contador), 32'd10);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_rst_valids", 32'(valids), 32'd0);
        check("async_rst_data", 32'(data_out_contador), 32'd0);
        req = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
        tick();
        read_one(2'd0, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/contadores_resp.md
Name: contadores_resp

Overview:
- Word-counter responder for the PCIe layer; it is the target side of the req/idx counter-read interface.
- Keeps one counter per output FIFO (fifo5..fifo8) and counts each successful pop seen on that FIFO's read port.
- On a req from the test/host side, returns the selected count on data_out_contador with valids asserted.
- Sits beside the output FIFO bank and takes the layer FSM's idle indication.

Parameters:
- CNT_W, 5, counter and data_out_contador width in bits.
- FIFO_UNITS, 4, number of counted FIFOs; fixed at 4 by the port list, used for indexing only.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_L  input  1  asynchronous active-low reset.
- idle  input  1  layer FSM is in IDLE; counter reads are accepted only while this is high.
- fifo5_rd  input  1  read strobe for output FIFO 5.
- fifo5_empty  input  1  empty flag of output FIFO 5.
- fifo6_rd, fifo7_rd, fifo8_rd  input  1 each  read strobes for FIFOs 6-8.
- fifo6_empty, fifo7_empty, fifo8_empty  input  1 each  empty flags for FIFOs 6-8.
- req  input  1  counter read request.
- idx  input  2  counter select: 0=fifo5, 1=fifo6, 2=fifo7, 3=fifo8.
- data_out_contador  output  CNT_W  selected count.
- valids  output  1  data_out_contador is valid this cycle.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, named reset_L.
  - reset_L=0 immediately clears all four counters, data_out_contador=0, valids=0, and forces the FSM to WAIT.
  - Reset may assert mid-response; the next cycle after release starts in WAIT with all counts at 0.
- Counting:
  - A pop on FIFO n is fifoN_rd=1 and fifoN_empty=0 at a rising edge; each pop increments cntN by 1.
  - rd while empty is not counted.
  - Counters wrap modulo 2^CNT_W (31 -> 0 at default). Counters never saturate.
  - All four counters update independently in the same cycle.
- FSM, registered, two states:
  - WAIT: valids=0, data_out_contador=0. If req=1 and idle=1 -> SERVE, else stay.
  - SERVE: valids=1, data_out_contador = cnt[idx] sampled at the edge that entered or held SERVE. If req=1 and idle=1 -> stay (a new sample each cycle), else -> WAIT.
- Latency:
  - Response arrives 1 cycle after the request edge.
  - Back-to-back requests with changing idx give one result per cycle, in order.
- req=1 with idle=0 is ignored: no response, counters unaffected.
- Pop and read of the same counter in the same cycle: the reported value is the pre-increment count; the increment still takes effect.
- idx is sampled only with req; idx changes while req=0 have no effect.
- Counting is independent of idle and req.

Optional Feature:
- Macro: CONTADORES_CLR_ON_READ_EN.
- Defined: each accepted read clears the selected counter at the same edge the response is sampled.
  - If a pop to that FIFO occurs in the same cycle, the counter becomes 1, not 0.
  - The reported value is the pre-clear count.
- Undefined: reads are non-destructive; counters only change on pop, wrap, or reset.

Test Plan:
- Reset then idle=1, req=1 with idx=0,1,2,3 on consecutive cycles, no pops -> valids=1 for 4 cycles starting 1 cycle after the first req, data_out_contador=0 each cycle, valids=0 the cycle after req drops.
- 6 pops on fifo5, 6 on fifo6, 6 on fifo7, 0 on fifo8, plus 3 fifo8_rd strobes with fifo8_empty=1; then read idx 0..3 -> 6, 6, 6, 0.
- 33 pops on fifo5, then read idx=0 -> 1 (wrap past 31).
- req=1, idx=1 with idle=0 for 3 cycles -> valids stays 0 and data_out_contador stays 0; then idle=1 -> response with cnt6 one cycle later.
- cnt7=4; in the same cycle pop fifo7 and req with idx=2 -> data_out_contador=4; a re-read gives 5, or 1 with CONTADORES_CLR_ON_READ_EN defined.
- cnt5=10; assert reset_L=0 during SERVE -> valids=0 and data_out_contador=0 immediately (asynchronous); after release, read idx=0 -> 0.
